// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- 8N1 UART receiver (LSB first) with input synchroniser,
// start-bit glitch rejection, mid-bit sampling, receive buffer and sticky
// error flags. Feeds the UART data register read by the CPU on int3.
//
// Optional build macro: UART_RX_FIFO_EN
//   undefined : single holding register (FIFO_DEPTH ignored)
//   defined   : FIFO_DEPTH-entry receive FIFO, q = head, rd pops
//
// Ports:
//   clk          system clock
//   nreset       asynchronous active-low reset
//   rxd          raw serial input (asynchronous, idle high)
//   rd           one-cycle read strobe, consumes the byte on q
//   clr_err      one-cycle strobe, clears frame_err and overrun
//   q            received byte (head of buffer)
//   valid        q holds an unread byte
//   frame_err    sticky: a stop bit was sampled low
//   overrun      sticky: a byte was dropped because the buffer was full
//   rx_interrupt one-cycle pulse per byte accepted into the buffer
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       rxd,
   input  logic       rd,
   input  logic       clr_err,
   output logic [7:0] q,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_interrupt
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // ------------------------------------------------------------------
   // Input synchroniser: both flops reset to the idle (high) level so a
   // reset never looks like a start bit.
   // ------------------------------------------------------------------
   logic rx_meta, rx_s;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
      end
   end

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    idx, idx_nx;
   logic [7:0]    sh, sh_nx;
   logic          byte_done;   // stop bit good, sh holds a full byte
   logic          stop_err;    // stop bit sampled low

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         sh    <= sh_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      idx_nx    = idx;
      sh_nx     = sh;
      byte_done = 1'b0;
      stop_err  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nx = S_START;
               cnt_nx   = '0;
            end
         end
         S_START: begin
            // Re-check the line half a bit in: a short low pulse is noise.
            if (cnt == HALF_C) begin
               cnt_nx = '0;
               if (rx_s) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx = S_DATA;
                  idx_nx   = '0;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_DATA: begin
            // Counter was re-based at mid start bit, so the wrap lands
            // in the middle of each data bit.
            if (cnt == LAST_C) begin
               cnt_nx = '0;
               sh_nx  = {rx_s, sh[7:1]};
               if (idx == 3'd7) state_nx = S_STOP;
               else             idx_nx   = idx + 3'd1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt == LAST_C) begin
               cnt_nx = '0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  state_nx  = S_IDLE;
               end else begin
                  stop_err = 1'b1;
                  state_nx = S_BREAK;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_BREAK: begin
            // Wait out a held-low line so a break yields a single error.
            if (rx_s) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Receive buffer
   // ------------------------------------------------------------------
   logic ovr_set;

`ifdef UART_RX_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0]   fcnt;
   logic          empty, full, pop, push;

   assign empty   = (fcnt == '0);
   assign full    = (fcnt == (PW+1)'(FIFO_DEPTH));
   assign pop     = rd && !empty;
   // A full FIFO still takes the byte when the head leaves this cycle.
   assign push    = byte_done && (!full || pop);
   assign ovr_set = byte_done && full && !pop;

   assign q     = mem[rp];
   assign valid = !empty;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wp           <= '0;
         rp           <= '0;
         fcnt         <= '0;
         rx_interrupt <= 1'b0;
      end else begin
         rx_interrupt <= push;
         if (push) begin
            mem[wp] <= sh;
            wp      <= wp + PW'(1);
         end
         if (pop) rp <= rp + PW'(1);
         case ({push, pop})
            2'b10:   fcnt <= fcnt + (PW+1)'(1);
            2'b01:   fcnt <= fcnt - (PW+1)'(1);
            default: fcnt <= fcnt;
         endcase
      end
   end
`else
   logic accept;

   // rd in the delivery cycle frees the register for the new byte.
   assign accept  = byte_done && (!valid || rd);
   assign ovr_set = byte_done && valid && !rd;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         q            <= '0;
         valid        <= 1'b0;
         rx_interrupt <= 1'b0;
      end else begin
         rx_interrupt <= accept;
         if (accept) begin
            q     <= sh;
            valid <= 1'b1;
         end else if (rd) begin
            valid <= 1'b0;
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Sticky error flags: a new event beats a simultaneous clear.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (stop_err)     frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
         if (ovr_set)      overrun   <= 1'b1;
         else if (clr_err) overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed testbench for uart_rx_byte at CLKS_PER_BIT=8.
module tb_uart_rx_byte;

   localparam int CPB = 8;
   localparam int FD  = 4;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       rxd = 1'b1;
   logic       rd = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] q;
   logic       valid, frame_err, overrun, rx_interrupt;

   int tests_run = 0;
   int fails = 0;
   int irq_cnt = 0;
   int irq0;
   int n;

   uart_rx_byte #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .nreset(nreset), .rxd(rxd), .rd(rd), .clr_err(clr_err),
      .q(q), .valid(valid), .frame_err(frame_err), .overrun(overrun),
      .rx_interrupt(rx_interrupt)
   );

   always #5 clk = ~clk;

   // Counts cycles with the interrupt high, so a stretched pulse shows up.
   always @(negedge clk) if (rx_interrupt) irq_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put(input logic v);
      rxd = v;
      tick(CPB);
   endtask

   // Full frame; rd_stop pulses rd on the edge where the byte is delivered
   // (7th edge of the stop bit).
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit rd_stop);
      put(1'b0);
      for (int i = 0; i < 8; i++) put(b[i]);
      rxd = stop_b;
      for (int i = 0; i < CPB; i++) begin
         tick(1);
         if (rd_stop) rd = (i == 5);
      end
      rd = 1'b0;
   endtask

   task automatic read_pulse();
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   task automatic clr_pulse();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_q", q, 8'h00);
      chk("rst_valid", valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_irq", rx_interrupt, 0);
      nreset = 1'b1;
      tick(CPB);

      // 0xA5 with latency: 2 sync edges + 76 START-to-delivery + register
      irq0 = irq_cnt;
      n = 0;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         while (!valid && n < 200) begin
            tick(1);
            n++;
         end
      join
      chk("a5_lat_window", (n >= 77 && n <= 81), 1);
      chk("a5_q", q, 8'hA5);
      tick(3);
      chk("a5_irq_1cyc", irq_cnt - irq0, 1);
      read_pulse();
      chk("a5_rd_clears", valid, 0);
      chk("a5_q_hold", q, 8'hA5);
      read_pulse();
      chk("rd_empty_ignored", valid, 0);

      // Start-bit glitch
      irq0 = irq_cnt;
      rxd = 1'b0;
      tick(2);
      rxd = 1'b1;
      tick(CPB * 3);
      chk("glitch_valid", valid, 0);
      chk("glitch_irq", irq_cnt - irq0, 0);
      send_frame(8'h3C, 1'b1, 1'b0);
      tick(2);
      chk("3c_q", q, 8'h3C);
      chk("3c_valid", valid, 1);
      chk("3c_irq", irq_cnt - irq0, 1);
      read_pulse();

      // Bad stop bit
      irq0 = irq_cnt;
      send_frame(8'h55, 1'b0, 1'b0);
      rxd = 1'b1;
      tick(CPB);
      chk("55_ferr", frame_err, 1);
      chk("55_valid", valid, 0);
      chk("55_irq", irq_cnt - irq0, 0);
      send_frame(8'h12, 1'b1, 1'b0);
      tick(2);
      chk("12_q", q, 8'h12);
      chk("12_ferr_sticky", frame_err, 1);
      clr_pulse();
      chk("clr_ferr", frame_err, 0);
      read_pulse();

      // Break: long low gives one error, no byte
      irq0 = irq_cnt;
      rxd = 1'b0;
      tick(CPB * 25);
      rxd = 1'b1;
      tick(CPB * 2);
      chk("brk_ferr", frame_err, 1);
      chk("brk_valid", valid, 0);
      chk("brk_irq", irq_cnt - irq0, 0);
      clr_pulse();

`ifdef UART_RX_FIFO_EN
      // FIFO fill past depth
      irq0 = irq_cnt;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      tick(3);
      chk("fifo_irq", irq_cnt - irq0, 4);
      chk("fifo_ovr", overrun, 1);
      for (int i = 1; i <= 4; i++) begin
         chk("fifo_valid", valid, 1);
         chk("fifo_q", q, 32'(i));
         read_pulse();
      end
      chk("fifo_empty", valid, 0);
      clr_pulse();
      send_frame(8'h99, 1'b1, 1'b0);
      tick(2);
`else
      // Overrun without rd
      irq0 = irq_cnt;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      tick(3);
      chk("ovr_q", q, 8'h11);
      chk("ovr_flag", overrun, 1);
      chk("ovr_irq", irq_cnt - irq0, 1);
      rd = 1'b1;
      clr_err = 1'b1;
      tick(1);
      rd = 1'b0;
      clr_err = 1'b0;
      chk("ovr_clr", overrun, 0);
      chk("ovr_rd_valid", valid, 0);

      // rd coincides with delivery: new byte replaces, no overrun
      irq0 = irq_cnt;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1);
      tick(2);
      chk("rdd_q", q, 8'h22);
      chk("rdd_valid", valid, 1);
      chk("rdd_ovr", overrun, 0);
      chk("rdd_irq", irq_cnt - irq0, 2);
`endif

      // Reset mid-DATA
      put(1'b0);
      put(1'b1);
      put(1'b0);
      nreset = 1'b0;
      #1;
      chk("mrst_q", q, 8'h00);
      chk("mrst_valid", valid, 0);
      chk("mrst_ferr", frame_err, 0);
      chk("mrst_ovr", overrun, 0);
      chk("mrst_irq", rx_interrupt, 0);
      rxd = 1'b1;
      tick(2);
      nreset = 1'b1;
      tick(CPB * 12);
      chk("mrst_no_partial", valid, 0);
      irq0 = irq_cnt;
      send_frame(8'h7E, 1'b1, 1'b0);
      tick(2);
      chk("7e_q", q, 8'h7E);
      chk("7e_valid", valid, 1);
      chk("7e_irq", irq_cnt - irq0, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
